// File: rtl/fb_pixel_packer.sv
// Packs PIX_W-bit pixels MSB-first into WORD_W-bit sequential frame-buffer writes, one frame per frame_start.
// First wr_req one cycle after the pixel completing a word; pix_ready stays low while a full word awaits wr_gnt.
module fb_pixel_packer #(
  parameter int PIX_W     = 24,
  parameter int WORD_W    = 16,
  parameter int NUM_COLS  = 640,
  parameter int NUM_ROWS  = 480,
  parameter int ADDR_W    = 20,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  input  logic              wr_gnt,
  output logic              busy,
  output logic              frame_done
);

  localparam int ACC_W     = PIX_W + WORD_W - 1;
  localparam int CNT_W     = $clog2(ACC_W + 1);
  localparam int NUM_PIX   = NUM_ROWS * NUM_COLS;
  localparam int PIX_CNT_W = $clog2(NUM_PIX + 1);

  localparam logic [63:0] FRAME_WORDS =
    (64'(NUM_PIX) * 64'(PIX_W) + 64'(WORD_W) - 64'd1) / 64'(WORD_W);
  localparam logic [63:0] ADDR_SPACE = 64'd1 << ADDR_W;

  localparam logic [CNT_W-1:0]     WORD_CNT  = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0]     PIX_BITS  = CNT_W'(PIX_W);
  localparam logic [PIX_CNT_W-1:0] PIX_TOTAL = PIX_CNT_W'(NUM_PIX);
  localparam logic [PIX_CNT_W-1:0] PIX_ONE   = PIX_CNT_W'(1);
  localparam logic [ADDR_W-1:0]    BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]    ADDR_ONE  = ADDR_W'(1);

  if (64'(BASE_ADDR) + FRAME_WORDS > ADDR_SPACE) begin : g_addr_range_check
    $error("fb_pixel_packer: frame of %0d words from BASE_ADDR %0d exceeds %0d-bit address space",
           FRAME_WORDS, BASE_ADDR, ADDR_W);
  end

  if (WORD_W < 2) begin : g_word_width_check
    $error("fb_pixel_packer: WORD_W must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ACC_W-1:0]      acc;
  logic [CNT_W-1:0]      acc_cnt;
  logic [PIX_CNT_W-1:0]  pix_cnt;
  logic [ACC_W-1:0]      pix_ext;
  logic                  accept;
  logic                  grant;
  logic                  frame_go;

  // Valid bits are kept left-justified with zeros below, so the flush word pads itself.
  assign pix_ext  = {pix_data, {(WORD_W-1){1'b0}}};
  assign wr_data  = acc[ACC_W-1 -: WORD_W];
  assign accept   = pix_valid && pix_ready;
  assign grant    = wr_req && wr_gnt;
  assign frame_go = (state == IDLE) && frame_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (frame_start) state_nxt = RUN;
      end
      RUN: begin
        if ((pix_cnt == PIX_TOTAL) && (acc_cnt < WORD_CNT)) begin
          state_nxt = (acc_cnt != '0) ? FLUSH : DONE;
        end
      end
      FLUSH: begin
        if (wr_gnt) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    pix_ready  = (state == RUN) && (acc_cnt < WORD_CNT) && (pix_cnt < PIX_TOTAL);
    wr_req     = (acc_cnt >= WORD_CNT) || (state == FLUSH);
    busy       = (state == RUN) || (state == FLUSH);
    frame_done = (state == DONE);
  end

  // Accept needs acc_cnt < WORD_W while a drain needs a full word or FLUSH, so they never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      acc_cnt <= '0;
      pix_cnt <= '0;
      wr_addr <= BASE;
    end else if (frame_go) begin
      acc     <= '0;
      acc_cnt <= '0;
      pix_cnt <= '0;
      wr_addr <= BASE;
    end else if (accept) begin
      acc     <= acc | (pix_ext >> acc_cnt);
      acc_cnt <= acc_cnt + PIX_BITS;
      pix_cnt <= pix_cnt + PIX_ONE;
    end else if (grant) begin
      acc     <= acc << WORD_W;
      acc_cnt <= (state == FLUSH) ? '0 : (acc_cnt - WORD_CNT);
      wr_addr <= wr_addr + ADDR_ONE;
    end
  end

endmodule
